decimal_entry_pad: RTL and testbench
====================================

DECIMAL_ENTRY_PAD -- requirements
Module: decimal_entry_pad

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning consecutive stable clocks (10 ms at 100 MHz) before a button level is accepted.
REQ-002 SHALL have port CLK100MHZ  input  1  100 MHz board clock; all logic is in this single domain.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_enter  input  1 each  raw asynchronous push-buttons, active-high.
REQ-005 SHALL have port ones, tens, hundreds  output  4 each  current BCD digits being edited.
REQ-006 SHALL have port digit_sel  output  2  edited digit: 0 = ones, 1 = tens, 2 = hundreds.
REQ-007 SHALL have port value_out  output  8  last converted binary value.
REQ-008 SHALL have port value_valid  output  1  one-cycle pulse when value_out updates.
REQ-009 SHALL have port overflow  output  1  last conversion exceeded 255.
REQ-010 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any mismatch restarts the count.
REQ-012 A 0->1 transition of a debounced level SHALL produce exactly one single-cycle press event; holding a button SHALL NOT repeat.
REQ-013 Same-cycle press events SHALL be prioritised enter > up > down > left > right; lower-priority events in that cycle SHALL be dropped.
REQ-014 Up SHALL increment the selected digit (9 wraps to 0); down SHALL decrement it (0 wraps to 9); other digits are unchanged.
REQ-015 Left SHALL increment digit_sel (2 wraps to 0); right SHALL decrement it (0 wraps to 2).
REQ-016 The FSM SHALL have states IDLE, CONV, DONE. IDLE->CONV on an enter event; CONV lasts exactly 3 cycles; CONV->DONE; DONE->IDLE after 1 cycle.
REQ-017 CONV SHALL use a 10-bit accumulator cleared on entry, computing acc = acc*10 + digit in order hundreds, tens, ones, one digit per cycle.
REQ-018 In DONE: if acc <= 255, value_out = acc[7:0] and overflow = 0; else value_out = 255 (saturated) and overflow = 1. value_valid SHALL be high for that single DONE cycle.
REQ-019 Latency: enter event in cycle N -> value_valid high in cycle N+4; busy SHALL be high in cycles N+1..N+3.
REQ-020 While the FSM is in CONV or DONE, all press events SHALL be discarded; digits and digit_sel stay frozen.
REQ-021 value_out and overflow SHALL hold their values between conversions.

Reset
REQ-022 Asserting reset_n low SHALL asynchronously force: digits 0, digit_sel 0, value_out 0, value_valid 0, overflow 0, busy 0, FSM IDLE, debounced levels 0, debounce counters 0.
REQ-023 Reset during CONV SHALL abort the conversion with no value_valid pulse, and value_out SHALL read 0.
REQ-024 After reset is released, a button already held SHALL generate one press event only once it has been stable for DEBOUNCE_CYCLES.

Structure
REQ-025 Package decimal_entry_pkg SHALL hold the FSM state type, MAX_DIGIT = 9, MAX_SEL = 2, SAT_VALUE = 255 and CONV_STEPS = 3.
REQ-026 One sub-module, button_debouncer (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), SHALL be instantiated five times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Up pressed 3 times, left, up 2 times, enter -> ones = 3, tens = 2, value_out = 23, value_valid pulses once, 4 cycles after the enter event.
REQ-028 Digits 2,5,6 (hundreds,tens,ones), enter -> value_out = 255, overflow = 1; then ones set to 5, enter -> value_out = 255, overflow = 0.
REQ-029 Up bouncing 1-0-1 every 2 cycles, then held 10 cycles -> exactly one increment.
REQ-030 Ones = 0, down -> ones = 9; digit_sel = 0, right -> digit_sel = 2.
REQ-031 Enter and up debounced in the same cycle -> conversion runs, no increment; up pressed during busy -> ignored.
REQ-032 reset_n low 2 cycles after the enter event -> no value_valid, all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/decimal_entry_pad_pkg.sv
// rtl/decimal_entry_pad_pkg.sv - shared types, constants and digit helpers for the decimal entry pad
// Purpose: FSM state type, digit/selector limits, saturation value, conversion length,
//          button index map and BCD digit wrap helpers.
package decimal_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_DIGIT  = 4'd9;
    localparam logic [1:0] MAX_SEL    = 2'd2;
    localparam logic [7:0] SAT_VALUE  = 8'd255;
    localparam logic [1:0] CONV_STEPS = 2'd3;

    // Bit positions of the buttons in the press-event vector
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ENTER = 4;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= MAX_DIGIT) ? 4'd0 : d + 4'd1;
    endfunction

    // Out-of-range codes cannot occur; they map to MAX_DIGIT so the digit stays legal
    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return ((d == 4'd0) || (d > MAX_DIGIT)) ? MAX_DIGIT : d - 4'd1;
    endfunction

endpackage

// File: rtl/decimal_entry_pad_if.sv
// rtl/decimal_entry_pad_if.sv - display/result bundle of the decimal entry pad
// Purpose: groups the edited digits, selector and conversion result.
// master: driven by decimal_entry_pad; slave: observed by a consumer.
interface decimal_entry_pad_if;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [1:0] digit_sel;
    logic [7:0] value_out;
    logic       value_valid;
    logic       overflow;
    logic       busy;

    modport master (
        output ones, tens, hundreds, digit_sel, value_out, value_valid, overflow, busy
    );

    modport slave (
        input ones, tens, hundreds, digit_sel, value_out, value_valid, overflow, busy
    );
endinterface

// File: rtl/decimal_entry_pad_debouncer.sv
// rtl/decimal_entry_pad_debouncer.sv - 2-FF synchronizer, debounce counter and press pulse
// Ports: CLK100MHZ clock, reset_n async active-low reset, i_btn raw button,
//        o_press single-cycle pulse when the debounced level rises.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK100MHZ,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_count;

    // The counter runs only while the synchronized sample differs from the
    // accepted level; any sample agreeing with the level restarts it.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_count <= '0;
            end else if (r_count == LAST) begin
                r_level <= r_sync2;
                r_count <= '0;
                r_press <= r_sync2;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/decimal_entry_pad.sv
// rtl/decimal_entry_pad.sv - three-digit BCD entry pad with BCD-to-binary conversion
// Ports: CLK100MHZ clock, reset_n async active-low reset,
//        btn_up/btn_down/btn_left/btn_right/btn_enter raw active-high buttons,
//        pad (master): ones/tens/hundreds digits, digit_sel, value_out,
//        value_valid pulse, overflow flag, busy.
module decimal_entry_pad
    import decimal_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset_n,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_enter,
    decimal_entry_pad_if.master  pad
);

    logic [4:0] w_btn;
    logic [4:0] w_press;

    assign w_btn = {btn_enter, btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .CLK100MHZ (CLK100MHZ),
            .reset_n   (reset_n),
            .i_btn     (w_btn[g]),
            .o_press   (w_press[g])
        );
    end

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_step;
    logic [9:0] r_acc;
    logic [3:0] r_digit [0:2];
    logic [1:0] r_sel;
    logic [7:0] r_value;
    logic       r_overflow;
    logic       w_busy;
    logic       w_valid;
    logic [3:0] w_conv_digit;
    logic [9:0] w_acc_next;

    // Step 0 takes hundreds, step 2 takes ones
    assign w_conv_digit = r_digit[MAX_SEL - r_step];
    assign w_acc_next   = r_acc * 10'd10 + {6'd0, w_conv_digit};

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: if (w_press[BTN_ENTER]) w_state_next = ST_CONV;
            ST_CONV: begin
                w_busy = 1'b1;
                if (r_step == CONV_STEPS - 2'd1) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_valid      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Edits happen only in IDLE; the if/else chain realises the press priority
    // and silently drops lower-priority events of the same cycle.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) r_digit[i] <= 4'd0;
            r_sel      <= 2'd0;
            r_step     <= 2'd0;
            r_acc      <= 10'd0;
            r_value    <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press[BTN_ENTER]) begin
                        r_acc  <= 10'd0;
                        r_step <= 2'd0;
                    end else if (w_press[BTN_UP]) begin
                        r_digit[r_sel] <= digit_inc(r_digit[r_sel]);
                    end else if (w_press[BTN_DOWN]) begin
                        r_digit[r_sel] <= digit_dec(r_digit[r_sel]);
                    end else if (w_press[BTN_LEFT]) begin
                        r_sel <= (r_sel >= MAX_SEL) ? 2'd0 : r_sel + 2'd1;
                    end else if (w_press[BTN_RIGHT]) begin
                        r_sel <= (r_sel == 2'd0) ? MAX_SEL : r_sel - 2'd1;
                    end
                end
                ST_CONV: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + 2'd1;
                    // Result is latched on the last step so it is stable throughout DONE
                    if (r_step == CONV_STEPS - 2'd1) begin
                        if (w_acc_next > 10'(SAT_VALUE)) begin
                            r_value    <= SAT_VALUE;
                            r_overflow <= 1'b1;
                        end else begin
                            r_value    <= w_acc_next[7:0];
                            r_overflow <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pad.ones        = r_digit[0];
    assign pad.tens        = r_digit[1];
    assign pad.hundreds    = r_digit[2];
    assign pad.digit_sel   = r_sel;
    assign pad.value_out   = r_value;
    assign pad.value_valid = w_valid;
    assign pad.overflow    = r_overflow;
    assign pad.busy        = w_busy;

endmodule

// File: tb/tb_decimal_entry_pad.sv
// tb/tb_decimal_entry_pad.sv - self-checking bench for decimal_entry_pad
module tb_decimal_entry_pad;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_enter = 1'b0;

    decimal_entry_pad_if pad ();

    decimal_entry_pad #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK100MHZ (clk),
        .reset_n   (reset_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_enter (btn_enter),
        .pad       (pad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int value;
        int ovf;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   errors = 0;
    int   checks = 0;
    int   m_dig[3] = '{0, 0, 0};
    int   m_sel = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            3: btn_right = v;
            default: btn_enter = v;
        endcase
    endtask

    task automatic check_pad(input string tag);
        check({tag, ".ones"}, pad.ones, m_dig[0]);
        check({tag, ".tens"}, pad.tens, m_dig[1]);
        check({tag, ".hundreds"}, pad.hundreds, m_dig[2]);
        check({tag, ".digit_sel"}, pad.digit_sel, m_sel);
    endtask

    // 0 up, 1 down, 2 left, 3 right
    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(8);
        set_btn(b, 1'b0);
        tick(8);
        case (b)
            0: m_dig[m_sel] = (m_dig[m_sel] == 9) ? 0 : m_dig[m_sel] + 1;
            1: m_dig[m_sel] = (m_dig[m_sel] == 0) ? 9 : m_dig[m_sel] - 1;
            2: m_sel = (m_sel == 2) ? 0 : m_sel + 1;
            default: m_sel = (m_sel == 0) ? 2 : m_sel - 1;
        endcase
    endtask

    // Enter is driven at cycle k; its event lands in cycle k+6, busy in k+7..k+9,
    // value_valid in k+10. up_off >= 0 also raises up that many cycles after enter.
    task automatic convert(input int up_off);
        int   k, v;
        exp_t t;
        k = cyc;
        v = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        t.value = (v > 255) ? 255 : v;
        t.ovf   = (v > 255) ? 1 : 0;
        t.cyc   = k + 10;
        q.push_back(t);
        btn_enter = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == up_off) btn_up = 1'b1;
            @(negedge clk);
            check("busy", pad.busy, (i >= 7 && i <= 9) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        btn_enter = 1'b0;
        btn_up = 1'b0;
        tick(10);
    endtask

    always @(negedge clk) begin
        if (reset_n && pad.value_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", pad.value_valid, 0);
            end else begin
                e_mon = q.pop_front();
                check("value_out", pad.value_out, e_mon.value);
                check("overflow", pad.overflow, e_mon.ovf);
                check("valid_cycle", cyc, e_mon.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tick(3);
        check_pad("reset");
        check("reset.value_out", pad.value_out, 0);
        check("reset.valid", pad.value_valid, 0);
        check("reset.overflow", pad.overflow, 0);
        check("reset.busy", pad.busy, 0);
        reset_n = 1'b1;
        tick(2);

        // ones = 3, tens = 2 -> 23
        repeat (3) press(0);
        press(2);
        repeat (2) press(0);
        check_pad("entry23");
        convert(-1);
        check("hold.value_out", pad.value_out, 23);

        // 256 saturates, then 255 exactly
        repeat (3) press(0);
        press(2);
        repeat (2) press(0);
        press(3);
        press(3);
        repeat (3) press(0);
        check_pad("entry256");
        convert(-1);
        press(1);
        check_pad("entry255");
        convert(-1);
        check("hold.value_out255", pad.value_out, 255);
        check("hold.overflow0", pad.overflow, 0);

        // bouncing up, then held: one increment
        repeat (3) begin
            btn_up = 1'b1; tick(2);
            btn_up = 1'b0; tick(2);
        end
        btn_up = 1'b1; tick(10);
        btn_up = 1'b0; tick(10);
        m_dig[0] = m_dig[0] + 1;
        check_pad("bounce");

        // enter wins over simultaneous up; up during busy is dropped
        convert(0);
        check_pad("enter_up_same");
        convert(2);
        check_pad("up_during_busy");

        // reset two cycles after the enter event aborts the conversion
        k = cyc;
        btn_enter = 1'b1;
        tick(8);
        check("pre_reset.busy", pad.busy, 1);
        check("pre_reset.cyc", cyc, k + 8);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort.value_out", pad.value_out, 0);
        check("abort.busy", pad.busy, 0);
        check("abort.valid", pad.value_valid, 0);
        tick(2);
        btn_enter = 1'b0;
        reset_n = 1'b1;
        m_dig = '{0, 0, 0};
        m_sel = 0;
        tick(20);
        check_pad("abort");
        check("abort.value_out_after", pad.value_out, 0);
        check("abort.overflow_after", pad.overflow, 0);

        // wrap boundaries
        press(1);
        press(3);
        check_pad("wrap");

        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
